// File: rtl/secuenciador_dir.sv
// Address sequencer: each enabled cycle it counts, jumps, calls or returns.
// A small return stack holds call return addresses and reports empty, full and a sticky error flag.
module secuenciador_dir #(
    parameter int              AW       = 8,
    parameter int              DEPTH    = 4,
    parameter logic [AW-1:0]   RST_ADDR = {AW{1'b0}}
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          EN,
    input  logic          CARGA,
    input  logic [AW-1:0] DIR_SALTO,
    input  logic          LLAMADA,
    input  logic          RETORNO,
    output logic [AW-1:0] DIRECCION,
    output logic          PILA_VACIA,
    output logic          PILA_LLENA,
    output logic          ERROR
);

    localparam int             IW      = $clog2(DEPTH);
    localparam int             PW      = IW + 1;
    localparam logic [PW-1:0]  CNT_MAX = PW'(DEPTH);
    localparam logic [PW-1:0]  CNT_CERO = {PW{1'b0}};

    logic [AW-1:0] dir_q, dir_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          error_q, error_d;
    logic          vacia_q, vacia_d;
    logic          llena_q, llena_d;
    logic [AW-1:0] pila_q [DEPTH];
    logic [AW-1:0] pila_d [DEPTH];

    logic [AW-1:0] dir_inc_s;
    logic [PW-1:0] cnt_m1_s;
    logic [IW-1:0] idx_top_s;
    logic [IW-1:0] idx_push_s;

    assign dir_inc_s  = dir_q + {{(AW-1){1'b0}}, 1'b1};
    assign cnt_m1_s   = cnt_q - {{(PW-1){1'b0}}, 1'b1};
    assign idx_top_s  = cnt_m1_s[IW-1:0];
    assign idx_push_s = cnt_q[IW-1:0];

    // Next-state: action priority is return, then call, then load, then increment.
    always_comb begin
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        pila_d  = pila_q;
        if (EN) begin
            if (RETORNO) begin
                if (cnt_q != CNT_CERO) begin
                    dir_d = pila_q[idx_top_s];
                    cnt_d = cnt_m1_s;
                end else begin
                    error_d = 1'b1;
                    dir_d   = dir_inc_s;
                end
            end else if (LLAMADA) begin
                if (cnt_q != CNT_MAX) begin
                    pila_d[idx_push_s] = dir_inc_s;
                    dir_d              = DIR_SALTO;
                    cnt_d              = cnt_q + {{(PW-1){1'b0}}, 1'b1};
                end else begin
                    error_d = 1'b1;
                    dir_d   = dir_inc_s;
                end
            end else if (CARGA) begin
                dir_d = DIR_SALTO;
            end else begin
                dir_d = dir_inc_s;
            end
        end else begin
            dir_d = dir_q;
        end
    end

    // Status flags are derived from the next count so they change together with it.
    always_comb begin
        vacia_d = (cnt_d == CNT_CERO);
        llena_d = (cnt_d == CNT_MAX);
    end

    // State registers with synchronous reset; stack contents are cleared for determinism.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dir_q   <= RST_ADDR;
            cnt_q   <= CNT_CERO;
            error_q <= 1'b0;
            vacia_q <= 1'b1;
            llena_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pila_q[i] <= {AW{1'b0}};
            end
        end else begin
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            vacia_q <= vacia_d;
            llena_q <= llena_d;
            for (int i = 0; i < DEPTH; i++) begin
                pila_q[i] <= pila_d[i];
            end
        end
    end

    assign DIRECCION  = dir_q;
    assign PILA_VACIA = vacia_q;
    assign PILA_LLENA = llena_q;
    assign ERROR      = error_q;

endmodule

// File: tb/tb_secuenciador_dir.sv
// Bench for secuenciador_dir: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a queue-based reference model.
module tb_secuenciador_dir;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          EN = 1'b0;
    logic          CARGA = 1'b0;
    logic [AW-1:0] DIR_SALTO = 8'h00;
    logic          LLAMADA = 1'b0;
    logic          RETORNO = 1'b0;
    logic [AW-1:0] DIRECCION;
    logic          PILA_VACIA;
    logic          PILA_LLENA;
    logic          ERROR;

    int n_total = 0;
    int n_pass  = 0;
    bit check_en = 1'b0;

    // Reference model state
    logic [AW-1:0] m_dir = 8'h00;
    logic [AW-1:0] m_stk[$];
    logic          m_err = 1'b0;

    secuenciador_dir #(.AW(AW), .DEPTH(DEPTH), .RST_ADDR(8'h00)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .CARGA(CARGA), .DIR_SALTO(DIR_SALTO),
        .LLAMADA(LLAMADA), .RETORNO(RETORNO), .DIRECCION(DIRECCION),
        .PILA_VACIA(PILA_VACIA), .PILA_LLENA(PILA_LLENA), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: applies the action rules to a queue-based stack on each rising edge.
    initial begin
        forever begin
            @(posedge CLK);
            if (RESET) begin
                m_dir = 8'h00;
                m_stk.delete();
                m_err = 1'b0;
            end else if (EN) begin
                if (RETORNO) begin
                    if (m_stk.size() > 0) m_dir = m_stk.pop_back();
                    else begin m_err = 1'b1; m_dir = m_dir + 8'd1; end
                end else if (LLAMADA) begin
                    if (m_stk.size() < DEPTH) begin
                        m_stk.push_back(m_dir + 8'd1);
                        m_dir = DIR_SALTO;
                    end else begin
                        m_err = 1'b1; m_dir = m_dir + 8'd1;
                    end
                end else if (CARGA) m_dir = DIR_SALTO;
                else m_dir = m_dir + 8'd1;
            end
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (check_en) begin
                chk("model_dir",   {24'd0, DIRECCION}, {24'd0, m_dir});
                chk("model_vacia", {31'd0, PILA_VACIA}, {31'd0, (m_stk.size() == 0)});
                chk("model_llena", {31'd0, PILA_LLENA}, {31'd0, (m_stk.size() == DEPTH)});
                chk("model_error", {31'd0, ERROR}, {31'd0, m_err});
            end
        end
    end

    task automatic cyc(input logic rst, input logic en, input logic carga, input logic ll,
                       input logic ret, input logic [7:0] salto);
        @(negedge CLK);
        RESET = rst; EN = en; CARGA = carga; LLAMADA = ll; RETORNO = ret; DIR_SALTO = salto;
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_dir(input string nm, input logic [7:0] v);
        chk(nm, {24'd0, DIRECCION}, {24'd0, v});
    endtask

    initial begin
        // Reset and plain counting
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_en = 1'b1;
        exp_dir("rst_dir", 8'h00);
        chk("rst_vacia", {31'd0, PILA_VACIA}, 32'd1);
        chk("rst_llena", {31'd0, PILA_LLENA}, 32'd0);
        chk("rst_error", {31'd0, ERROR}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); exp_dir("cnt1", 8'h01);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); exp_dir("cnt2", 8'h02);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); exp_dir("cnt3", 8'h03);
        chk("cnt_vacia", {31'd0, PILA_VACIA}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); exp_dir("cnt5", 8'h05);
        // Load
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40); exp_dir("carga40", 8'h40);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); exp_dir("inc41", 8'h41);
        // Call and return
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10); exp_dir("carga10", 8'h10);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80); exp_dir("call80", 8'h80);
        chk("call_vacia", {31'd0, PILA_VACIA}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); exp_dir("ret11", 8'h11);
        chk("ret_vacia", {31'd0, PILA_VACIA}, 32'd1);
        // Return wins over a simultaneous call, no error
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h90); exp_dir("call90", 8'h90);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA0); exp_dir("ret_ll12", 8'h12);
        chk("ret_ll_err", {31'd0, ERROR}, 32'd0);
        chk("ret_ll_vacia", {31'd0, PILA_VACIA}, 32'd1);
        // Four nested calls fill the stack; a fifth overflows
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h30);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h40);
        chk("three_llena", {31'd0, PILA_LLENA}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h50); exp_dir("call4", 8'h50);
        chk("four_llena", {31'd0, PILA_LLENA}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h60); exp_dir("ovf_dir", 8'h51);
        chk("ovf_err", {31'd0, ERROR}, 32'd1);
        chk("ovf_llena", {31'd0, PILA_LLENA}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); exp_dir("pop41", 8'h41);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); exp_dir("pop31", 8'h31);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); exp_dir("pop21", 8'h21);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); exp_dir("pop13", 8'h13);
        // Underflow at 8'h20, then EN=0 holds everything
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); exp_dir("unf_dir", 8'h21);
        chk("unf_err", {31'd0, ERROR}, 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77); exp_dir("hold_dir", 8'h21);
        chk("hold_vacia", {31'd0, PILA_VACIA}, 32'd1);
        // Wraparound of increment and of the pushed return address
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); exp_dir("wrap00", 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33); exp_dir("callFF", 8'h33);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); exp_dir("retwrap", 8'h00);
        chk("sticky_err", {31'd0, ERROR}, 32'd1);
        // Reset during a call wins
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55); exp_dir("rst_call", 8'h00);
        chk("rst_call_vacia", {31'd0, PILA_VACIA}, 32'd1);
        chk("rst_call_err", {31'd0, ERROR}, 32'd0);
        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85),
                ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30),
                ($urandom_range(0, 99) < 25), 8'($urandom));
        end
        @(negedge CLK);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
